// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_RUN,
        MUL_DONE
    } mul_state_t;

    localparam logic [4:0] XZR_IDX       = 5'd31;
    localparam int         MUL_WIDTH_DEF = 64;

endpackage

// File: rtl/iterative_multiplier_if.sv
// Operand request / write-back bundle between the control unit and the multiplier.
interface iterative_multiplier_if #(
    parameter int WIDTH = 64
);
    logic             Start;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic [4:0]       Rd;
    logic             HighSel;
    logic             Busy;
    logic [WIDTH-1:0] Result;
    logic [4:0]       RW;
    logic             RegWr;

    modport master (
        output Start, OpA, OpB, Rd, HighSel,
        input  Busy, Result, RW, RegWr
    );

    modport slave (
        input  Start, OpA, OpB, Rd, HighSel,
        output Busy, Result, RW, RegWr
    );
endinterface

// File: rtl/mul_step.sv
// One shift-add iteration: conditionally accumulate the multiplicand, then shift both operands.
module mul_step #(
    parameter int AW    = 64,
    parameter int WIDTH = 64
) (
    input  logic [AW-1:0]    acc,
    input  logic [AW-1:0]    mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic [AW-1:0]    acc_next,
    output logic [AW-1:0]    mcand_next,
    output logic [WIDTH-1:0] mplier_next
);

    always_comb begin
        acc_next    = mplier[0] ? (acc + mcand) : acc;
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
    end

endmodule

// File: rtl/iterative_multiplier.sv
// Multi-cycle unsigned shift-add multiplier (MUL, optionally UMULH) with start/busy handshake.
// Optional feature: define MUL_UMULH_EN for a double-width datapath and high-half selection.
module iterative_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEF,
    parameter int CNTW  = $clog2(WIDTH)
) (
    input  logic                  Clk,
    input  logic                  ResetL,
    iterative_multiplier_if.slave bus
);

`ifdef MUL_UMULH_EN
    localparam int AW = 2 * WIDTH;
`else
    localparam int AW = WIDTH;
`endif

    mul_state_t       state, state_next;
    logic [AW-1:0]    acc, mcand, acc_step, mcand_step;
    logic [WIDTH-1:0] mplier, mplier_step;
    logic [WIDTH-1:0] result, result_next;
    logic [CNTW-1:0]  cnt;
    logic [4:0]       rd_lat, rw;
    logic             busy, regwr;
    logic             accept, last;

    mul_step #(.AW(AW), .WIDTH(WIDTH)) u_step (
        .acc         (acc),
        .mcand       (mcand),
        .mplier      (mplier),
        .acc_next    (acc_step),
        .mcand_next  (mcand_step),
        .mplier_next (mplier_step)
    );

`ifdef MUL_UMULH_EN
    logic hi_lat;
    assign result_next = hi_lat ? acc_step[AW-1:WIDTH] : acc_step[WIDTH-1:0];
`else
    logic unused_highsel;
    assign unused_highsel = bus.HighSel;
    assign result_next    = acc_step[WIDTH-1:0];
`endif

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            MUL_IDLE: begin
                if (bus.Start) begin
                    accept     = 1'b1;
                    state_next = MUL_RUN;
                end
            end
            MUL_RUN: begin
                // Counter value WIDTH-1 marks the final multiplier bit
                if (cnt == CNTW'(WIDTH - 1)) begin
                    last       = 1'b1;
                    state_next = MUL_DONE;
                end
            end
            MUL_DONE: state_next = MUL_IDLE;
            default:  state_next = MUL_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            state <= MUL_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            rd_lat <= '0;
            rw     <= '0;
            result <= '0;
            busy   <= 1'b0;
            regwr  <= 1'b0;
`ifdef MUL_UMULH_EN
            hi_lat <= 1'b0;
`endif
        end else if (accept) begin
            acc    <= '0;
            mcand  <= AW'(bus.OpA);
            mplier <= bus.OpB;
            cnt    <= '0;
            rd_lat <= bus.Rd;
            busy   <= 1'b1;
`ifdef MUL_UMULH_EN
            hi_lat <= bus.HighSel;
`endif
        end else if (state == MUL_RUN) begin
            acc    <= acc_step;
            mcand  <= mcand_step;
            mplier <= mplier_step;
            cnt    <= cnt + CNTW'(1);
            if (last) begin
                result <= result_next;
                rw     <= rd_lat;
                // XZR destination completes silently
                regwr  <= (rd_lat != XZR_IDX);
            end
        end else if (state == MUL_DONE) begin
            regwr <= 1'b0;
            busy  <= 1'b0;
        end
    end

    assign bus.Busy   = busy;
    assign bus.Result = result;
    assign bus.RW     = rw;
    assign bus.RegWr  = regwr;

endmodule

// File: tb/tb_iterative_multiplier.sv
// Scoreboard bench for iterative_multiplier: stimulus queues expected write-backs, a monitor checks completions.
module tb_iterative_multiplier;

    localparam int W = 64;

    logic Clk;
    logic ResetL;

    iterative_multiplier_if #(.WIDTH(W)) bus ();

    iterative_multiplier #(.WIDTH(W)) dut (
        .Clk    (Clk),
        .ResetL (ResetL),
        .bus    (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [W-1:0] res;
        logic [4:0]   rw;
        int           pulses;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: a completion is Busy falling; it must match the oldest queued expectation
    int busy_cnt = 0;
    int pulses   = 0;
    int wr_idx   = -1;
    bit prev_busy = 1'b0;

    always @(negedge Clk) begin
        exp_t e;
        if (!ResetL) begin
            busy_cnt  = 0;
            pulses    = 0;
            wr_idx    = -1;
            prev_busy = 1'b0;
        end else begin
            if (bus.RegWr === 1'b1) begin
                if (bus.Busy !== 1'b1) chk("regwr_outside_busy", 128'(bus.Busy), 128'(1));
                pulses++;
                wr_idx = busy_cnt;
            end
            if (bus.Busy === 1'b1) busy_cnt++;
            if (prev_busy && bus.Busy !== 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_completion", 128'(0), 128'(1));
                end else begin
                    e = sb_q.pop_front();
                    chk("result", 128'(bus.Result), 128'(e.res));
                    chk("rw", 128'(bus.RW), 128'(e.rw));
                    chk("regwr_pulses", 128'(pulses), 128'(e.pulses));
                    chk("busy_cycles", 128'(busy_cnt), 128'(W + 1));
                    if (e.pulses == 1) chk("regwr_latency", 128'(wr_idx), 128'(W));
                end
                busy_cnt = 0;
                pulses   = 0;
                wr_idx   = -1;
            end
            prev_busy = (bus.Busy === 1'b1);
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (bus.Busy === 1'b0) return;
            @(posedge Clk);
            #1;
        end
        chk("idle_timeout", 128'(bus.Busy), 128'(0));
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] rd,
                         input logic hs, input logic [W-1:0] res, input bit push);
        exp_t e;
        wait_idle();
        if (push) begin
            e.res    = res;
            e.rw     = rd;
            e.pulses = (rd != 5'd31) ? 1 : 0;
            sb_q.push_back(e);
        end
        bus.OpA     = a;
        bus.OpB     = b;
        bus.Rd      = rd;
        bus.HighSel = hs;
        bus.Start   = 1'b1;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
    endtask

    initial begin
        bus.Start   = 1'b1;
        bus.OpA     = 64'd3;
        bus.OpB     = 64'd5;
        bus.Rd      = 5'd9;
        bus.HighSel = 1'b0;
        ResetL      = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_busy", 128'(bus.Busy), 128'(0));
        chk("reset_regwr", 128'(bus.RegWr), 128'(0));
        chk("reset_result", 128'(bus.Result), 128'(0));
        chk("reset_rw", 128'(bus.RW), 128'(0));
        bus.Start = 1'b0;
        ResetL    = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk("idle_after_reset", 128'(bus.Busy), 128'(0));

        issue(64'd3, 64'd5, 5'd9, 1'b0, 64'd15, 1'b1);
        chk("busy_after_accept", 128'(bus.Busy), 128'(1));

        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
`ifdef MUL_UMULH_EN
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, 1'b1, 64'd1, 1'b1);
        issue(64'h1_0000_0000, 64'h1_0000_0000, 5'd6, 1'b1, 64'd1, 1'b1);
        issue(64'h8000_0000_0000_0000, 64'd3, 5'd7, 1'b1, 64'd1, 1'b1);
`else
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        issue(64'h1_0000_0000, 64'h1_0000_0000, 5'd6, 1'b1, 64'd0, 1'b1);
        issue(64'h8000_0000_0000_0000, 64'd3, 5'd7, 1'b1, 64'h8000_0000_0000_0000, 1'b1);
`endif
        issue(64'd1, 64'h8000_0000_0000_0000, 5'd8, 1'b0, 64'h8000_0000_0000_0000, 1'b1);
        issue(64'd0, 64'hDEAD_BEEF, 5'd10, 1'b0, 64'd0, 1'b1);

        // Start held across E20 while running must not disturb the 7x6 operation
        issue(64'd7, 64'd6, 5'd5, 1'b0, 64'd42, 1'b1);
        repeat (19) @(posedge Clk);
        #1;
        bus.OpA   = 64'd100;
        bus.OpB   = 64'd100;
        bus.Rd    = 5'd4;
        bus.Start = 1'b1;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;

        issue(64'd8, 64'd8, 5'd31, 1'b0, 64'd64, 1'b1);

        // Abort at E30: no write-back expected for this one
        issue(64'd5, 64'd5, 5'd12, 1'b0, 64'd25, 1'b0);
        repeat (29) @(posedge Clk);
        #1;
        ResetL = 1'b0;
        #1;
        chk("abort_busy", 128'(bus.Busy), 128'(0));
        chk("abort_regwr", 128'(bus.RegWr), 128'(0));
        chk("abort_result", 128'(bus.Result), 128'(0));
        chk("abort_rw", 128'(bus.RW), 128'(0));
        repeat (2) @(posedge Clk);
        #1;
        ResetL = 1'b1;
        @(posedge Clk);
        #1;

        issue(64'd9, 64'd9, 5'd2, 1'b0, 64'd81, 1'b1);
        wait_idle();
        repeat (3) @(posedge Clk);
        #1;
        chk("scoreboard_empty", 128'(sb_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/iterative_multiplier.md
# iterative_multiplier

Multi-cycle 64-bit shift-add multiplier for the LEGv8 datapath. It consumes register-file read operands (BusA/BusB values) and produces a write-back triple (Result, RW, RegWr) that drives the register file's BusW/RW/RegWr inputs. It runs `MUL` (low 64 bits of the product) and, when configured, `UMULH` (high 64 bits). A start/busy handshake with fixed, deterministic latency lets the control unit stall the pipeline around it.

## Interface
- `WIDTH`, default 64: operand and result width.
- `CNTW`, default `$clog2(WIDTH)` (6): iteration counter width.
- `Clk`, input, 1: clock. All state updates on posedge.
- `ResetL`, input, 1: asynchronous, active-low reset.
- `Start`, input, 1: operation request. Sampled only in IDLE.
- `OpA`, input, WIDTH: multiplicand (BusA value).
- `OpB`, input, WIDTH: multiplier (BusB value).
- `Rd`, input, 5: destination register index.
- `HighSel`, input, 1: 1 selects the high product half (`UMULH`). Used only with `MUL_UMULH_EN`; ignored otherwise.
- `Busy`, output, 1: high from acceptance until the return to IDLE.
- `Result`, output, WIDTH: product. Registered and held until the next completion.
- `RW`, output, 5: destination index latched at acceptance.
- `RegWr`, output, 1: write strobe, a one-cycle pulse.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - If `Start` is 1 on a posedge, latch OpA, OpB, Rd and HighSel, clear the accumulator and counter, and go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - Each posedge processes one multiplier bit, LSB first.
  - If the multiplier LSB is 1, the accumulator adds the shifted multiplicand.
  - The multiplicand shifts left by 1 and the multiplier shifts right by 1.
  - The counter increments.
  - The edge on which the counter reaches WIDTH-1 performs the last step, loads Result, and goes to DONE.
- DONE:
  - RegWr = 1 only if the latched Rd ≠ 31. X31 is XZR, so the operation completes normally but no write strobe is issued.
  - The next posedge returns to IDLE with RegWr = 0.
- Always a fixed WIDTH iterations; there is no early termination on zero operands.
- Arithmetic: unsigned; the low half is identical for signed operands.
  - Without the macro: accumulator and multiplicand are WIDTH bits, and the sum is modulo 2^WIDTH.
- `Start` while Busy (RUN or DONE) is ignored; latched operands are unaffected.
- Reset, asynchronous, any time:
  - State IDLE; Busy = 0, RegWr = 0, Result = 0, RW = 0.
  - Accumulator, counter and operand registers cleared.
  - An aborted operation produces no write.

## Timing
- Acceptance edge E0 (Start = 1 in IDLE): Busy = 1 after E0.
- RUN occupies edges E1..E64 (for WIDTH = 64).
- After E64: state DONE; Result, RW valid; RegWr = 1.
- After E65: IDLE; Busy = 0, RegWr = 0.
- Latency from acceptance to the write strobe is WIDTH edges. Issue-to-issue interval is WIDTH+2 cycles.
- All outputs are registered, so they are stable across the intervening negedge, where the register file commits BusW.
- A new Start is accepted at earliest on E66; Busy = 0 is visible after E65.

## Configuration
- `MUL_UMULH_EN` defined:
  - Accumulator is 2·WIDTH bits and the multiplicand register is 2·WIDTH bits.
  - Result = high half when the latched HighSel = 1, low half otherwise.
- `MUL_UMULH_EN` undefined:
  - WIDTH-bit datapath only; HighSel is unconnected internally.
  - Result is always the low half.
- Latency and handshake are identical in both builds.

## Structure
- Shared package `mul_pkg`:
  - State enum (`MUL_IDLE`, `MUL_RUN`, `MUL_DONE`).
  - `XZR_IDX = 5'd31`.
  - Default width constant 64.
- One sub-module, `mul_step`: combinational single-iteration shift-add (accumulator, multiplicand, multiplier in → next values out).
- The FSM, counter and output registers stay in the top block.

## Test plan
- Reset: hold ResetL = 0 with Start = 1 → Busy = 0, RegWr = 0, Result = 0, RW = 0. After release, no activity until a Start edge.
- Basic MUL: OpA = 3, OpB = 5, Rd = 9, one-cycle Start → Busy high after E0; RegWr = 1 only between E64 and E65; Result = 15; RW = 9; Busy = 0 after E65.
- Wrap and high half: OpA = 0xFFFF_FFFF_FFFF_FFFF, OpB = 2:
  - HighSel = 0 → Result = 0xFFFF_FFFF_FFFF_FFFE.
  - With `MUL_UMULH_EN` and HighSel = 1 → Result = 1.
  - Without the macro, HighSel = 1 → Result still 0xFFFF_FFFF_FFFF_FFFE.
- Start during RUN: start 7×6, then at E20 assert Start with OpA = 100, OpB = 100, Rd = 4 → ignored; Result = 42, RW = original Rd, exactly one RegWr pulse.
- XZR: OpA = 8, OpB = 8, Rd = 31 → RegWr stays 0 for the whole operation; Busy timing unchanged; Result = 64.
- Reset mid-operation: drop ResetL at E30 → outputs zero immediately with no RegWr. A following 9×9 to Rd = 2 completes with Result = 81 and RegWr at E64.
